sipo_deserializer: RTL and testbench
====================================

# sipo_deserializer

Serial-in, parallel-out word receiver: the inbound counterpart of the team's parallel-load shift/storage registers. It samples a strobed serial bit stream, assembles `WIDTH`-bit words LSB first, and presents each completed word on a registered parallel output with a valid/ready handshake. It sits between a bit-level link front end and any word-wide consumer (register file, FIFO, counter load port).

## Interface
- `WIDTH`: default 8. Data bits per word; legal range 1 to 32.
- `clk`: input, 1 bit. Clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Reset; synchronous, active-high.
- `s_in`: input, 1 bit. Serial data bit; sampled only when `s_valid`=1.
- `s_valid`: input, 1 bit. Bit strobe; one bit is consumed per cycle with `s_valid`=1.
- `s_start`: input, 1 bit. Marks the current bit as bit 0 of a new word; qualified by `s_valid`.
- `out_data`: output, `WIDTH` bits. Last completed word, registered.
- `out_valid`: output, 1 bit. `out_data` holds an unconsumed word.
- `out_ready`: input, 1 bit. Consumer accepts the word when `out_valid`=1 and `out_ready`=1 at a rising edge.
- `overrun`: output, 1 bit. Sticky. A word completed while the output was full and not being accepted.
- `parity_err`: output, 1 bit. Parity result for the word in `out_data`. Constant 0 unless parity is compiled in.

## Operation
- **States.**
  - `IDLE`: the block ignores `s_valid` bits unless `s_start`=1.
  - `SHIFT`: a word is in progress.
  - `PAR`: waiting for the parity bit. Exists only with `SIPO_PARITY_EN`.
- **Bit counter.** 5 bits, counts data bits received in the current word.
- **Shift register.** `sh <= {s_in, sh[WIDTH-1:1]}` on every accepted bit. The first bit received lands in `out_data[0]` and the last in `out_data[WIDTH-1]`.
- **IDLE transitions.** `s_valid`=1 and `s_start`=1: shift, set count to 1, go to `SHIFT`. If `WIDTH`=1 the word completes on this bit instead.
- **SHIFT, bit accepted.** `s_valid`=1 and `s_start`=0: shift and increment count. When count reaches `WIDTH`, the word completes, or the block goes to `PAR` if parity is enabled.
- **SHIFT, restart.** `s_valid`=1 and `s_start`=1: discard the partial word, silently. That bit becomes bit 0 of a new word and count is set to 1.
- **No strobe.** `s_valid`=0 holds all state, in any state. `s_start` without `s_valid` is ignored.
- **Word completion.** Return to `IDLE`. A word that ends on bit N is followed by a new `s_start` bit at the earliest on the next strobe; back-to-back words are legal with zero idle cycles.
- **Output register, at completion:**
  - Slot empty (`out_valid`=0), or being drained this edge (`out_ready`=1): load `out_data`/`parity_err`, `out_valid`=1.
  - Slot full and `out_ready`=0: drop the new word, keep the old one, set `overrun`=1.
- **Drain without completion.** When `out_valid` and `out_ready` are both 1 with no completion, `out_valid` goes to 0 next cycle. `out_data` keeps its stale value.
- **Overrun clearing.** `overrun` clears only on `reset`.

## Timing
- **Reset values.** `out_data`=0, `out_valid`=0, `overrun`=0, `parity_err`=0; state `IDLE`, count 0, shift register 0.
- **Reset mid-word.** Discards the partial word and any pending output word.
- **Latency.** The edge sampling the final bit (last data bit, or parity bit) also loads the output register. `out_valid`=1 is visible in the cycle after that edge.
- **Minimum word time.** `WIDTH` strobes, or `WIDTH`+1 with parity. Throughput is one word per `WIDTH` strobes when the consumer holds `out_ready`=1.
- **Simultaneous accept and complete.** `out_valid` stays 1 and `out_data` switches to the new word. No overrun.
- **Handshake rule.** `out_data` must not change while `out_valid`=1 and `out_ready`=0.
- **Combinational paths.** None from inputs to outputs.

## Configuration
- **Macro:** `SIPO_PARITY_EN`.
- **Defined:**
  - Each word carries one extra even-parity bit after the `WIDTH` data bits.
  - The word completes on the parity bit.
  - `parity_err` = XOR of data and parity bit, registered together with `out_data`.
  - A word with bad parity is still delivered.
  - `s_start` in `PAR` restarts, the same as in `SHIFT`.
- **Undefined:**
  - No `PAR` state.
  - The word completes on data bit `WIDTH`.
  - `parity_err` is tied to 0.

## Test plan
- **Reset check.** Hold `reset` 2 cycles with random inputs → all outputs 0.
- **Single word.** `WIDTH`=8, bits 1,0,1,1,0,0,1,0 with `s_start` on the first, `out_ready`=1 → `out_data`=0x4D, `out_valid` high for exactly 1 cycle, `overrun`=0.
- **Gapped strobes and restart.** `s_valid` toggling 1/0, with `s_start` reasserted after 3 bits → only the later word appears. Send 0xA5 LSB first → `out_data`=0xA5.
- **Back-pressure.** `out_ready`=0, send 0x11 then 0x22 → `out_data` stays 0x11 and `overrun`=1. Then `out_ready`=1 → `out_valid` drops, and `overrun` stays 1 until reset.
- **Back-to-back accept.** `out_ready` pulsed on the same edge the second word completes → `out_valid` stays 1, `out_data` changes 0x11→0x22, `overrun`=0.
- **Parity (`SIPO_PARITY_EN`).** Data 0x03 with parity 0 → `parity_err`=0. Data 0x03 with parity 1 → `parity_err`=1. Reset asserted mid-word → no word delivered.

Source files
------------

// File: rtl/sipo_deserializer_if.sv
// Serial-bit input and parallel-word output bundle for sipo_deserializer.
// The master drives the bit stream and out_ready; the slave is the deserializer.
interface sipo_deserializer_if #(parameter int WIDTH = 8);
    logic             s_in;
    logic             s_valid;
    logic             s_start;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             parity_err;

    modport master (
        output s_in, s_valid, s_start, out_ready,
        input  out_data, out_valid, overrun, parity_err
    );

    modport slave (
        input  s_in, s_valid, s_start, out_ready,
        output out_data, out_valid, overrun, parity_err
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out word receiver: assembles WIDTH-bit words LSB first behind a valid/ready slot.
// Optional even-parity bit after each word is compiled in with `define SIPO_PARITY_EN.
module sipo_deserializer #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                reset,
    sipo_deserializer_if.slave bus
);
    localparam logic [4:0] LAST = 5'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifdef SIPO_PARITY_EN
        PAR   = 2'd2,
`endif
        SHIFT = 2'd1
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       count_q, count_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             perr_q, perr_d;

    logic [WIDTH-1:0] shifted;
    logic             done;
    logic [WIDTH-1:0] doneWord;
    logic             donePerr;

    generate
        if (WIDTH == 1) begin : gNarrow
            assign shifted = bus.s_in;
        end else begin : gWide
            assign shifted = {bus.s_in, sh_q[WIDTH-1:1]};
        end
    endgenerate

    // A start bit always begins a new word, discarding any partial one.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sh_d     = sh_q;
        done     = 1'b0;
        doneWord = shifted;
        donePerr = 1'b0;
        if (bus.s_valid) begin
            if (bus.s_start) begin
                sh_d    = shifted;
                count_d = 5'd1;
                if (WIDTH == 1) begin
                    count_d = 5'd0;
`ifdef SIPO_PARITY_EN
                    state_d = PAR;
`else
                    done    = 1'b1;
                    state_d = IDLE;
`endif
                end else begin
                    state_d = SHIFT;
                end
            end else begin
                case (state_q)
                    SHIFT: begin
                        sh_d    = shifted;
                        count_d = count_q + 5'd1;
                        if (count_q == LAST) begin
                            count_d = 5'd0;
`ifdef SIPO_PARITY_EN
                            state_d = PAR;
`else
                            done    = 1'b1;
                            state_d = IDLE;
`endif
                        end
                    end
`ifdef SIPO_PARITY_EN
                    PAR: begin
                        done     = 1'b1;
                        doneWord = sh_q;
                        donePerr = (^sh_q) ^ bus.s_in;
                        state_d  = IDLE;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // The slot accepts a new word if empty or being drained on the same edge.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        perr_d    = perr_q;
        if (done) begin
            if (!valid_q || bus.out_ready) begin
                data_d  = doneWord;
                perr_d  = donePerr;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= 5'd0;
            sh_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end

    assign bus.out_data   = data_q;
    assign bus.out_valid  = valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.parity_err = perr_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: a bit-queue reference model predicts delivered words,
// a negedge monitor compares them and the slot flags whenever the DUT presents output.
module tb_sipo_deserializer;
    localparam int WIDTH = 8;
`ifdef SIPO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    bit   running = 0;
    bit   randReady = 0;

    sipo_deserializer_if #(.WIDTH(WIDTH)) bus ();

    sipo_deserializer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: collected bits of the current word and the output slot.
    bit                 bitsQ[$];
    bit                 modelActive = 0;
    bit                 modelValid = 0;
    bit                 modelOverrun = 0;
    logic [WIDTH:0]     expQ[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model words as lists of bits; the value is the weighted sum of the first WIDTH bits.
    always @(posedge clk) begin
        bit             complete;
        logic [31:0]    w;
        bit             p;
        complete = 0;
        w = 0;
        p = 0;
        if (reset) begin
            bitsQ.delete();
            modelActive = 0;
            modelValid = 0;
            modelOverrun = 0;
            expQ.delete();
        end else begin
            if (bus.s_valid) begin
                if (bus.s_start) begin
                    bitsQ.delete();
                    bitsQ.push_back(bus.s_in);
                    modelActive = 1;
                end else if (modelActive) begin
                    bitsQ.push_back(bus.s_in);
                end
                if (modelActive && bitsQ.size() == NBITS) begin
                    complete = 1;
                    for (int i = 0; i < WIDTH; i++) w = w + (32'(bitsQ[i]) << i);
`ifdef SIPO_PARITY_EN
                    for (int i = 0; i < NBITS; i++) p = p ^ bitsQ[i];
`endif
                    bitsQ.delete();
                    modelActive = 0;
                end
            end
            if (complete) begin
                if (!modelValid || bus.out_ready) begin
                    expQ.push_back({p, w[WIDTH-1:0]});
                    modelValid = 1;
                end else begin
                    modelOverrun = 1;
                end
            end else if (modelValid && bus.out_ready) begin
                modelValid = 0;
            end
        end
    end

    // Monitor: compare the presented word against the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (running && !reset) begin
            checkOutput("out_valid", 32'(bus.out_valid), 32'(modelValid));
            checkOutput("overrun", 32'(bus.overrun), 32'(modelOverrun));
            if (bus.out_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_word: got %h expected no word at %0t", bus.out_data, $time);
                end else begin
                    e = expQ[0];
                    checkOutput("out_data", 32'(bus.out_data), 32'(e[WIDTH-1:0]));
                    checkOutput("parity_err", 32'(bus.parity_err), 32'(e[WIDTH]));
                    if (bus.out_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit b, input bit start, input int gaps);
        repeat (gaps) begin
            bus.s_valid = 1'b0;
            bus.s_start = 1'($urandom);
            bus.s_in    = 1'($urandom);
            if (randReady) bus.out_ready = 1'($urandom);
            stepCycle();
        end
        bus.s_valid = 1'b1;
        bus.s_start = start;
        bus.s_in    = b;
        if (randReady) bus.out_ready = 1'($urandom);
        stepCycle();
        bus.s_valid = 1'b0;
        bus.s_start = 1'b0;
    endtask

    task automatic sendWord(input logic [WIDTH-1:0] data, input bit badPar, input int maxGap, input bit readyOnLast);
        bit b;
        for (int i = 0; i < NBITS; i++) begin
            b = (i < WIDTH) ? data[i] : ((^data) ^ badPar);
            if (readyOnLast && i == NBITS - 1) bus.out_ready = 1'b1;
            applyStimulus(b, i == 0, (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
        end
        if (readyOnLast) bus.out_ready = 1'b0;
    endtask

    task automatic sendPartial(input int n, input int maxGap);
        for (int i = 0; i < n; i++) applyStimulus(1'($urandom), i == 0, int'($urandom_range(0, maxGap)));
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) begin
            bus.s_valid = 1'($urandom);
            bus.s_start = 1'($urandom);
            bus.s_in    = 1'($urandom);
            stepCycle();
        end
        reset = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_start = 1'b0;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        doReset();
        @(negedge clk);
        checkOutput("reset_data", 32'(bus.out_data), 32'h0);
        checkOutput("reset_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("reset_overrun", 32'(bus.overrun), 32'h0);
        checkOutput("reset_perr", 32'(bus.parity_err), 32'h0);
        running = 1;

        // Single word, consumer always ready: valid for exactly one cycle.
        bus.out_ready = 1'b1;
        sendWord(8'h4D, 0, 0, 0);
        @(negedge clk);
        checkOutput("single_data", 32'(bus.out_data), 32'h4D);
        checkOutput("single_valid", 32'(bus.out_valid), 32'h1);
        stepCycle();
        @(negedge clk);
        checkOutput("single_valid_drop", 32'(bus.out_valid), 32'h0);
        checkOutput("single_overrun", 32'(bus.overrun), 32'h0);

        // Gapped strobes with a restart after three bits.
        sendPartial(3, 1);
        sendWord(8'hA5, 0, 1, 0);
        @(negedge clk);
        checkOutput("restart_data", 32'(bus.out_data), 32'hA5);
        checkOutput("restart_valid", 32'(bus.out_valid), 32'h1);

        // Back-pressure: second word dropped, overrun sticky.
        doReset();
        bus.out_ready = 1'b0;
        sendWord(8'h11, 0, 0, 0);
        sendWord(8'h22, 0, 0, 0);
        @(negedge clk);
        checkOutput("bp_data", 32'(bus.out_data), 32'h11);
        checkOutput("bp_overrun", 32'(bus.overrun), 32'h1);
        bus.out_ready = 1'b1;
        stepCycle();
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_valid_drop", 32'(bus.out_valid), 32'h0);
        checkOutput("bp_overrun_sticky", 32'(bus.overrun), 32'h1);

        // Accept on the same edge the next word completes.
        doReset();
        sendWord(8'h11, 0, 0, 0);
        sendWord(8'h22, 0, 0, 1);
        @(negedge clk);
        checkOutput("b2b_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("b2b_data", 32'(bus.out_data), 32'h22);
        checkOutput("b2b_overrun", 32'(bus.overrun), 32'h0);

        // Reset mid-word discards both partial and pending words.
        sendPartial(4, 0);
        doReset();
        @(negedge clk);
        checkOutput("midreset_valid", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 1'b1;
        sendWord(8'h3C, 0, 0, 0);
        @(negedge clk);
        checkOutput("midreset_next", 32'(bus.out_data), 32'h3C);

`ifdef SIPO_PARITY_EN
        sendWord(8'h03, 0, 0, 0);
        @(negedge clk);
        checkOutput("par_good", 32'(bus.parity_err), 32'h0);
        sendWord(8'h03, 1, 0, 0);
        @(negedge clk);
        checkOutput("par_bad", 32'(bus.parity_err), 32'h1);
        checkOutput("par_bad_data", 32'(bus.out_data), 32'h03);
`endif

        // Randomized traffic with random back-pressure, restarts and resets.
        randReady = 1;
        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 2) begin
                sendPartial(int'($urandom_range(1, NBITS - 1)), 2);
            end else if (r == 2) begin
                sendPartial(int'($urandom_range(1, NBITS - 1)), 2);
                doReset();
            end
            sendWord(WIDTH'($urandom), $urandom_range(0, 3) == 0, 2, 0);
        end
        randReady = 0;
        bus.out_ready = 1'b1;
        repeat (4) stepCycle();
        @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
